enc_quad_decoder: RTL and testbench
===================================

Name: enc_quad_decoder

Overview:
Front-end stage for the Pmod ENC rotary encoder. It feeds the encoder MMIO slot core with clean, single-cycle events. It synchronizes and debounces the four raw Pmod pins, then decodes the A/B quadrature pair with a direction-tracking FSM. It keeps a wrapping signed position count and produces step, direction, button-edge and illegal-transition pulses for the slot core to register.

Parameters:
DB_CYCLES, 100000, consecutive stable cycles required before a debounced level changes (1 ms at 100 MHz); must be >= 2
CNT_W, 16, width of the signed position counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ja_a  in  1  raw encoder phase A (idles high)
ja_b  in  1  raw encoder phase B (idles high)
ja_btn  in  1  raw push-button, active-high
ja_sw  in  1  raw slide switch
clr  in  1  synchronous clear of position
step_tick  out  1  one-cycle pulse per decoded step
step_dir  out  1  direction of the last step: 1 = CW, 0 = CCW
position  out  CNT_W  signed two's-complement step count
btn_level  out  1  debounced button level
btn_tick  out  1  one-cycle pulse on btn_level rising edge
sw_level  out  1  debounced switch level
err_tick  out  1  one-cycle pulse on an illegal A/B transition

Behaviour:
- Interface: reset is asynchronous, active-high; clk is the clock. All flops use posedge clk and posedge reset.
- Reset values:
  - step_tick, step_dir, position, btn_tick, err_tick = 0.
  - btn_level and sw_level = 0.
  - Debounced A and B = 1; synchronizers preset to 1 for A and B, 0 for btn and sw.
  - FSM = IDLE.
- Synchronizer: each raw input passes a 2-flop synchronizer.
- Debounce, per input:
  - A counter runs while the synced value differs from the debounced value.
  - The counter clears whenever the two are equal.
  - The debounced value flips on the cycle the count reaches DB_CYCLES-1, i.e. after DB_CYCLES consecutive differing cycles.
- FSM on debounced {A,B}:
  - States: IDLE(11), CW1(01), CW2(00), CW3(10), CCW1(10), CCW2(00), CCW3(01), ERR.
  - CW path: IDLE→CW1→CW2→CW3→IDLE. The CW3→IDLE transition issues a step with dir=1.
  - CCW path: IDLE→CCW1→CCW2→CCW3→IDLE. The CCW3→IDLE transition issues a step with dir=0.
  - Backtracking one legal Gray step moves to the previous state with no step (CW1→IDLE, CW2→CW1, CW3→CW2, and the CCW mirrors).
  - A state with no input change holds.
  - Both bits changing in one cycle: pulse err_tick, go to ERR. ERR stays until {A,B}=11, then moves to IDLE with no step.
- Outputs are registered:
  - step_tick, step_dir and the position update appear the cycle after the completing transition.
  - step_dir holds its value between steps.
- Position:
  - +1 on a CW step, -1 on a CCW step, modulo 2^CNT_W.
  - Wraps 0x7FFF→0x8000 and 0x0000→0xFFFF (CNT_W=16).
  - When clr and a step coincide, clr wins: position = 0, but step_tick and step_dir still fire.
- btn_tick is asserted one cycle after btn_level goes 0→1.
- Reset mid-sequence abandons the partial step; no tick is emitted.

Optional Feature:
Macro ENC_X4_EN.
- Defined: x4 decoding. Every legal Gray transition emits step_tick; position moves ±1 per transition (4 per detent). Backtracking emits a step of the opposite direction.
- Undefined: x1 full-cycle decoding as described above.
- ERR handling is identical in both modes.

Decomposition:
- Package enc_pkg holds:
  - enum quad_state_t (the 8 states);
  - localparam DEFAULT_DB_CYCLES = 100000;
  - 2-bit constants AB_IDLE = 2'b11 and AB_BOTH = 2'b00.
- Sub-module enc_debounce: 1-bit synchronizer plus debounce, parameterised by DB_CYCLES and RST_VAL, instantiated four times.

Test Plan:
All scenarios use DB_CYCLES=4 and CNT_W=16, with each phase held 10 cycles.
- Reset, then idle 11 for 50 cycles → all ticks 0, position = 0x0000, no err_tick.
- CW sequence 11→01→00→10→11 → exactly one step_tick, step_dir = 1, position = 0x0001. Then a CCW sequence twice → position = 0xFFFF, step_dir = 0.
- Glitch: A pulled low for 3 cycles at idle → no state change, no ticks. Partial CW 11→01→00→01→11 → no step, position unchanged.
- Illegal jump 11→00 → one err_tick, no step. Then 10, 11 → back to IDLE, and a following full CW sequence → +1.
- Preload 0x7FFF via 32767 CW steps (or force), then one CW step → position = 0x8000. clr asserted on the step_tick cycle → position = 0x0000, step_tick still seen.
- ja_btn held high 10 cycles → btn_level rises and btn_tick pulses once. Release → no tick. ENC_X4_EN build with one CW detent → 4 step_ticks, position = 4.

Source files
------------

// File: rtl/enc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | enc_pkg                                                                |
// | Shared state type and constants for the Pmod ENC quadrature front-end. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package enc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CW1  = 3'd1,
    ST_CW2  = 3'd2,
    ST_CW3  = 3'd3,
    ST_CCW1 = 3'd4,
    ST_CCW2 = 3'd5,
    ST_CCW3 = 3'd6,
    ST_ERR  = 3'd7
  } quad_state_t;

  localparam int DEFAULT_DB_CYCLES = 100000;

  localparam logic [1:0] AB_IDLE = 2'b11;
  localparam logic [1:0] AB_BOTH = 2'b00;

  // {A,B} level that a state implies; ERR reports idle so any exit compares against 11
  function automatic logic [1:0] state_ab(input quad_state_t s);
    case (s)
      ST_CW1, ST_CCW3: state_ab = 2'b01;
      ST_CW2, ST_CCW2: state_ab = AB_BOTH;
      ST_CW3, ST_CCW1: state_ab = 2'b10;
      default:         state_ab = AB_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_debounce.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | enc_debounce                                                           |
// | Two-flop synchronizer followed by a stable-count debouncer.            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module enc_debounce
  import enc_pkg::*;
#(
  parameter int   DB_CYCLES = DEFAULT_DB_CYCLES,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int               CW     = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]    C_LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // The level only follows after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= RST_VAL;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign dout = r_level;

endmodule
`default_nettype wire

// File: rtl/enc_quad_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | enc_quad_decoder                                                       |
// | Debounced Pmod ENC front-end: quadrature FSM, position count, ticks.   |
// | Define ENC_X4_EN for x4 decoding (a step on every legal transition).   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module enc_quad_decoder
  import enc_pkg::*;
#(
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ja_a,
  input  logic             ja_b,
  input  logic             ja_btn,
  input  logic             ja_sw,
  input  logic             clr,
  output logic             step_tick,
  output logic             step_dir,
  output logic [CNT_W-1:0] position,
  output logic             btn_level,
  output logic             btn_tick,
  output logic             sw_level,
  output logic             err_tick
);

`ifdef ENC_X4_EN
  localparam logic C_X4 = 1'b1;
`else
  localparam logic C_X4 = 1'b0;
`endif

  logic        w_a;
  logic        w_b;
  logic [1:0]  w_ab;
  logic [1:0]  w_chg;

  quad_state_t r_state;
  quad_state_t w_state_nxt;
  logic        w_legal;
  logic        w_complete;
  logic        w_cw;
  logic        w_step;
  logic        w_err;
  logic        r_btn_d;

  enc_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_a (
    .clk(clk), .reset(reset), .din(ja_a), .dout(w_a)
  );
  enc_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_b (
    .clk(clk), .reset(reset), .din(ja_b), .dout(w_b)
  );
  enc_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_btn (
    .clk(clk), .reset(reset), .din(ja_btn), .dout(btn_level)
  );
  enc_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_sw (
    .clk(clk), .reset(reset), .din(ja_sw), .dout(sw_level)
  );

  assign w_ab  = {w_a, w_b};
  assign w_chg = w_ab ^ state_ab(r_state);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Each non-ERR state pins down {A,B}, so a two-bit difference is an illegal jump
  always_comb begin
    w_state_nxt = r_state;
    w_legal     = 1'b0;
    w_complete  = 1'b0;
    w_cw        = 1'b0;
    w_err       = 1'b0;
    if (r_state == ST_ERR) begin
      if (w_ab == AB_IDLE) begin
        w_state_nxt = ST_IDLE;
      end
    end else if (w_chg == 2'b11) begin
      w_state_nxt = ST_ERR;
      w_err       = 1'b1;
    end else if (w_chg != 2'b00) begin
      w_legal = 1'b1;
      case (r_state)
        ST_IDLE: begin
          w_cw        = (w_ab == 2'b01);
          w_state_nxt = w_cw ? ST_CW1 : ST_CCW1;
        end
        ST_CW1: begin
          w_cw        = (w_ab == AB_BOTH);
          w_state_nxt = w_cw ? ST_CW2 : ST_IDLE;
        end
        ST_CW2: begin
          w_cw        = (w_ab == 2'b10);
          w_state_nxt = w_cw ? ST_CW3 : ST_CW1;
        end
        ST_CW3: begin
          w_cw        = (w_ab == AB_IDLE);
          w_complete  = w_cw;
          w_state_nxt = w_cw ? ST_IDLE : ST_CW2;
        end
        ST_CCW1: begin
          w_cw        = (w_ab == AB_IDLE);
          w_state_nxt = w_cw ? ST_IDLE : ST_CCW2;
        end
        ST_CCW2: begin
          w_cw        = (w_ab == 2'b10);
          w_state_nxt = w_cw ? ST_CCW1 : ST_CCW3;
        end
        ST_CCW3: begin
          w_cw        = (w_ab == AB_BOTH);
          w_complete  = !w_cw;
          w_state_nxt = w_cw ? ST_CCW2 : ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign w_step = w_legal & (C_X4 | w_complete);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_tick <= 1'b0;
      step_dir  <= 1'b0;
      position  <= '0;
      err_tick  <= 1'b0;
      btn_tick  <= 1'b0;
      r_btn_d   <= 1'b0;
    end else begin
      step_tick <= w_step;
      err_tick  <= w_err;
      btn_tick  <= btn_level & ~r_btn_d;
      r_btn_d   <= btn_level;
      if (w_step) begin
        step_dir <= w_cw;
      end
      // clear takes priority over a coincident step; the tick still fires
      if (clr) begin
        position <= '0;
      end else if (w_step) begin
        position <= w_cw ? position + CNT_W'(1) : position - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enc_quad_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_enc_quad_decoder                                                    |
// | Randomized self-checking bench with a detent-offset reference model.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_enc_quad_decoder;

  localparam int DB   = 4;
  localparam int HOLD = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ja_a = 1'b1, ja_b = 1'b1, ja_btn = 1'b0, ja_sw = 1'b0, clr = 1'b0;
  logic        step_tick, step_dir, btn_level, btn_tick, sw_level, err_tick;
  logic [15:0] position;
  logic        s3_step_tick, s3_step_dir, s3_btn_level, s3_btn_tick, s3_sw_level, s3_err_tick;
  logic [2:0]  s3_position;

  enc_quad_decoder #(.DB_CYCLES(DB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ja_a(ja_a), .ja_b(ja_b), .ja_btn(ja_btn), .ja_sw(ja_sw),
    .clr(clr), .step_tick(step_tick), .step_dir(step_dir), .position(position),
    .btn_level(btn_level), .btn_tick(btn_tick), .sw_level(sw_level), .err_tick(err_tick)
  );

  // narrow copy sharing all inputs, used to observe signed wrap cheaply
  enc_quad_decoder #(.DB_CYCLES(DB), .CNT_W(3)) dut_s3 (
    .clk(clk), .reset(reset), .ja_a(ja_a), .ja_b(ja_b), .ja_btn(ja_btn), .ja_sw(ja_sw),
    .clr(clr), .step_tick(s3_step_tick), .step_dir(s3_step_dir), .position(s3_position),
    .btn_level(s3_btn_level), .btn_tick(s3_btn_tick), .sw_level(s3_sw_level), .err_tick(s3_err_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int n_cw = 0, n_ccw = 0, n_err = 0, n_btn = 0, n_s3 = 0;
  always @(negedge clk) begin
    if (step_tick) begin
      if (step_dir) n_cw++;
      else n_ccw++;
    end
    if (err_tick) n_err++;
    if (btn_tick) n_btn++;
    if (s3_step_tick) n_s3++;
  end

  // Model: signed quarter-step offset from the detent; +-4 completes a detent
  int          m_off = 0;
  bit          m_err = 1'b0;
  logic [1:0]  m_ab  = 2'b11;
  logic [15:0] m_pos = 16'h0000;
  logic        m_dir = 1'b0;
  int          e_cw = 0, e_ccw = 0, e_err = 0, e_btn = 0;

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b11:   return 0;
      2'b01:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] cw_next(input logic [1:0] ab);
    case (ab)
      2'b11:   return 2'b01;
      2'b01:   return 2'b00;
      2'b00:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [1:0] ccw_next(input logic [1:0] ab);
    case (ab)
      2'b11:   return 2'b10;
      2'b10:   return 2'b00;
      2'b00:   return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  task automatic model_step(input bit cw);
    if (cw) begin e_cw++; m_pos = m_pos + 16'd1; end
    else begin e_ccw++; m_pos = m_pos - 16'd1; end
    m_dir = cw;
  endtask

  task automatic model_ab(input logic [1:0] nab);
    int d;
    if (nab == m_ab) return;
    if (m_err) begin
      if (nab == 2'b11) begin m_err = 1'b0; m_off = 0; end
    end else if ((nab ^ m_ab) == 2'b11) begin
      e_err++;
      m_off = 0;
      m_err = (nab != 2'b11);
    end else begin
      d = (((gidx(nab) - gidx(m_ab) + 4) % 4) == 1) ? 1 : -1;
`ifdef ENC_X4_EN
      model_step(d == 1);
`else
      m_off = m_off + d;
      if (m_off == 4) begin model_step(1'b1); m_off = 0; end
      if (m_off == -4) begin model_step(1'b0); m_off = 0; end
`endif
    end
    m_ab = nab;
  endtask

  task automatic model_reset();
    m_off = 0; m_err = 1'b0; m_ab = 2'b11; m_pos = 16'h0000; m_dir = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive_phase(input logic [1:0] ab);
    ja_a = ab[1];
    ja_b = ab[0];
    model_ab(ab);
    wait_cycles(HOLD);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    wait_cycles(3);
    total++; if (step_tick !== 1'b0) begin bad++; $display("FAIL reset_step_tick got=%b want=0", step_tick); end
    total++; if (step_dir !== 1'b0) begin bad++; $display("FAIL reset_step_dir got=%b want=0", step_dir); end
    total++; if (position !== 16'h0000) begin bad++; $display("FAIL reset_position got=%h want=0000", position); end
    total++; if ({btn_level, btn_tick, sw_level, err_tick} !== 4'b0000) begin bad++; $display("FAIL reset_misc got=%b want=0000", {btn_level, btn_tick, sw_level, err_tick}); end
    reset = 1'b0;
    wait_cycles(50);
    total++; if (n_cw + n_ccw !== 0) begin bad++; $display("FAIL idle_steps got=%0d want=0", n_cw + n_ccw); end
    total++; if (n_err !== 0) begin bad++; $display("FAIL idle_err got=%0d want=0", n_err); end
    total++; if (position !== 16'h0000) begin bad++; $display("FAIL idle_position got=%h want=0000", position); end
  endtask

  task automatic test_cw_ccw();
    drive_phase(2'b01); drive_phase(2'b00); drive_phase(2'b10); drive_phase(2'b11);
    total++; if (n_cw !== e_cw) begin bad++; $display("FAIL cw_count got=%0d want=%0d", n_cw, e_cw); end
    total++; if (step_dir !== 1'b1) begin bad++; $display("FAIL cw_dir got=%b want=1", step_dir); end
    total++; if (position !== m_pos) begin bad++; $display("FAIL cw_position got=%h want=%h", position, m_pos); end
    for (int k = 0; k < 2; k++) begin
      drive_phase(2'b10); drive_phase(2'b00); drive_phase(2'b01); drive_phase(2'b11);
    end
    total++; if (n_ccw !== e_ccw) begin bad++; $display("FAIL ccw_count got=%0d want=%0d", n_ccw, e_ccw); end
    total++; if (step_dir !== 1'b0) begin bad++; $display("FAIL ccw_dir got=%b want=0", step_dir); end
    total++; if (position !== m_pos) begin bad++; $display("FAIL ccw_position got=%h want=%h", position, m_pos); end
    total++; if (s3_position !== m_pos[2:0]) begin bad++; $display("FAIL ccw_s3_position got=%h want=%h", s3_position, m_pos[2:0]); end
  endtask

  task automatic test_glitch();
    int cw0 = n_cw, ccw0 = n_ccw;
    ja_a = 1'b0;
    wait_cycles(3);
    ja_a = 1'b1;
    wait_cycles(HOLD);
    total++; if (n_cw !== cw0 || n_ccw !== ccw0) begin bad++; $display("FAIL glitch_steps got=%0d/%0d want=%0d/%0d", n_cw, n_ccw, cw0, ccw0); end
    total++; if (n_err !== e_err) begin bad++; $display("FAIL glitch_err got=%0d want=%0d", n_err, e_err); end
    drive_phase(2'b01); drive_phase(2'b00); drive_phase(2'b01); drive_phase(2'b11);
    total++; if (n_cw !== e_cw || n_ccw !== e_ccw) begin bad++; $display("FAIL partial_steps got=%0d/%0d want=%0d/%0d", n_cw, n_ccw, e_cw, e_ccw); end
    total++; if (position !== m_pos) begin bad++; $display("FAIL partial_position got=%h want=%h", position, m_pos); end
  endtask

  task automatic test_illegal();
    drive_phase(2'b00);
    total++; if (n_err !== e_err) begin bad++; $display("FAIL illegal_err got=%0d want=%0d", n_err, e_err); end
    total++; if (n_cw !== e_cw || n_ccw !== e_ccw) begin bad++; $display("FAIL illegal_steps got=%0d/%0d want=%0d/%0d", n_cw, n_ccw, e_cw, e_ccw); end
    drive_phase(2'b10); drive_phase(2'b11);
    drive_phase(2'b01); drive_phase(2'b00); drive_phase(2'b10); drive_phase(2'b11);
    total++; if (position !== m_pos) begin bad++; $display("FAIL recover_position got=%h want=%h", position, m_pos); end
    total++; if (n_cw !== e_cw || n_err !== e_err) begin bad++; $display("FAIL recover_counts got=%0d/%0d want=%0d/%0d", n_cw, n_err, e_cw, e_err); end
  endtask

  task automatic test_wrap_clr();
    bit seen = 1'b0;
    for (int i = 0; i < 64 && m_pos[2:0] != 3'd3; i++) drive_phase(cw_next(m_ab));
    for (int i = 0; i < 8 && m_pos[2:0] == 3'd3; i++) drive_phase(cw_next(m_ab));
    total++; if (s3_position !== 3'b100) begin bad++; $display("FAIL wrap_s3_position got=%b want=100", s3_position); end
    total++; if (position !== m_pos) begin bad++; $display("FAIL wrap_position got=%h want=%h", position, m_pos); end
    while (m_ab != 2'b11) drive_phase(cw_next(m_ab));
    drive_phase(2'b01); drive_phase(2'b00); drive_phase(2'b10);
    clr = 1'b1;
    ja_a = 1'b1; ja_b = 1'b1;
    model_ab(2'b11);
    m_pos = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      wait_cycles(1);
      if (step_tick) begin
        seen = 1'b1;
        total++; if (position !== 16'h0000) begin bad++; $display("FAIL clr_vs_step got=%h want=0000", position); end
        break;
      end
    end
    clr = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL clr_step_tick got=none want=pulse within 20 cycles"); end
    wait_cycles(HOLD);
    total++; if (position !== 16'h0000 || s3_position !== 3'b000) begin bad++; $display("FAIL clr_position got=%h/%b want=0000/000", position, s3_position); end
    total++; if (step_dir !== 1'b1 || n_cw !== e_cw) begin bad++; $display("FAIL clr_dir_count got=%b/%0d want=1/%0d", step_dir, n_cw, e_cw); end
  endtask

  task automatic test_button();
    ja_btn = 1'b1;
    e_btn++;
    wait_cycles(HOLD);
    total++; if (btn_level !== 1'b1) begin bad++; $display("FAIL btn_level_hi got=%b want=1", btn_level); end
    total++; if (n_btn !== e_btn) begin bad++; $display("FAIL btn_tick_rise got=%0d want=%0d", n_btn, e_btn); end
    ja_btn = 1'b0;
    wait_cycles(HOLD);
    total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL btn_level_lo got=%b want=0", btn_level); end
    total++; if (n_btn !== e_btn) begin bad++; $display("FAIL btn_tick_fall got=%0d want=%0d", n_btn, e_btn); end
    ja_sw = 1'b1;
    wait_cycles(HOLD);
    total++; if (sw_level !== 1'b1 || s3_sw_level !== 1'b1) begin bad++; $display("FAIL sw_level_hi got=%b want=1", sw_level); end
    ja_sw = 1'b0;
    wait_cycles(2);
    total++; if (sw_level !== 1'b1) begin bad++; $display("FAIL sw_level_debounce got=%b want=1", sw_level); end
    wait_cycles(HOLD);
    total++; if (sw_level !== 1'b0) begin bad++; $display("FAIL sw_level_lo got=%b want=0", sw_level); end
  endtask

  task automatic test_reset_mid();
    drive_phase(2'b01); drive_phase(2'b00);
    reset = 1'b1;
    ja_a = 1'b1; ja_b = 1'b1;
    model_reset();
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(HOLD);
    total++; if (n_cw !== e_cw || n_ccw !== e_ccw) begin bad++; $display("FAIL reset_mid_steps got=%0d/%0d want=%0d/%0d", n_cw, n_ccw, e_cw, e_ccw); end
    total++; if (position !== 16'h0000 || n_err !== e_err) begin bad++; $display("FAIL reset_mid_state got=%h/%0d want=0000/%0d", position, n_err, e_err); end
  endtask

  task automatic test_random();
    int r;
    logic [1:0] nab;
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        drive_phase($urandom_range(0, 1) ? cw_next(m_ab) : ccw_next(m_ab));
      end else if (r == 6) begin
        drive_phase(m_ab);
      end else if (r == 7) begin
        nab = ~m_ab;
        drive_phase(nab);
      end else if (r == 8) begin
        if ($urandom_range(0, 1)) ja_a = ~ja_a;
        else ja_b = ~ja_b;
        wait_cycles($urandom_range(1, DB - 1));
        ja_a = m_ab[1]; ja_b = m_ab[0];
        wait_cycles(HOLD);
      end else begin
        clr = 1'b1;
        wait_cycles(1);
        clr = 1'b0;
        m_pos = 16'h0000;
        wait_cycles(HOLD);
      end
      total++; if (n_cw !== e_cw) begin bad++; $display("FAIL rnd_cw it=%0d got=%0d want=%0d", it, n_cw, e_cw); end
      total++; if (n_ccw !== e_ccw) begin bad++; $display("FAIL rnd_ccw it=%0d got=%0d want=%0d", it, n_ccw, e_ccw); end
      total++; if (n_err !== e_err) begin bad++; $display("FAIL rnd_err it=%0d got=%0d want=%0d", it, n_err, e_err); end
      total++; if (position !== m_pos) begin bad++; $display("FAIL rnd_position it=%0d got=%h want=%h", it, position, m_pos); end
      total++; if (s3_position !== m_pos[2:0]) begin bad++; $display("FAIL rnd_s3_position it=%0d got=%b want=%b", it, s3_position, m_pos[2:0]); end
      total++; if (step_dir !== m_dir) begin bad++; $display("FAIL rnd_dir it=%0d got=%b want=%b", it, step_dir, m_dir); end
    end
    total++; if (n_s3 !== e_cw + e_ccw) begin bad++; $display("FAIL s3_step_total got=%0d want=%0d", n_s3, e_cw + e_ccw); end
  endtask

  initial begin
    test_reset();
    test_cw_ccw();
    test_glitch();
    test_illegal();
    test_wrap_clr();
    test_button();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
